// File: rtl/hamming_pkg.sv
// Shared SECDED Hamming(16,11) definitions: engine state type, codeword parity positions
// and the reference encode function reused by the decoder side.
package hamming_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_CAPT,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE
  } enc_state_t;

  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int P4_POS = 4;
  localparam int P8_POS = 8;

  // Parity bits sit at codeword positions 1/2/4/8, p0 at bit 0 makes the whole word even.
  function automatic logic [15:0] hamming_encode11(input logic [11:1] d);
    logic [15:0] cw;
    logic        p8;
    logic        p4;
    logic        p2;
    logic        p1;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    cw = {d[11:5], 1'b0, d[4:2], 1'b0, d[1], 1'b0, 1'b0, 1'b0};
    cw[P8_POS] = p8;
    cw[P4_POS] = p4;
    cw[P2_POS] = p2;
    cw[P1_POS] = p1;
    cw[P0_POS] = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    return cw;
  endfunction

endpackage

// File: rtl/hamming_enc_engine_if.sv
// Start/done handshake plus single-port byte memory bus of the Hamming encoder engine.
interface hamming_enc_engine_if #(
  parameter int ADDR_W = 8
);

  logic              start;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rdata;
  logic              mem_wr_en;
  logic [7:0]        mem_wdata;

  modport master (
    input  start,
    input  mem_rdata,
    output done,
    output mem_addr,
    output mem_rd_en,
    output mem_wr_en,
    output mem_wdata
  );

  modport slave (
    output start,
    output mem_rdata,
    input  done,
    input  mem_addr,
    input  mem_rd_en,
    input  mem_wr_en,
    input  mem_wdata
  );

endinterface

// File: rtl/hamming_parity_gen.sv
// Combinational 11-bit message to 16-bit SECDED codeword generator.
module hamming_parity_gen
  import hamming_pkg::*;
(
  input  logic [11:1] d_i,
  output logic [15:0] cw_o
);

  assign cw_o = hamming_encode11(d_i);

endmodule

// File: rtl/hamming_enc_engine.sv
// Autonomous SECDED encoder: reads NUM_MSGS 11-bit messages, writes 16-bit codewords, then raises done.
module hamming_enc_engine
  import hamming_pkg::*;
#(
  parameter int NUM_MSGS = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  hamming_enc_engine_if.master bus
);

  localparam int               IDX_W    = $clog2(NUM_MSGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSGS - 1);

  enc_state_t        state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [7:0]        lo_q;
  logic [15:0]       cw_q;
  logic [15:0]       cw_d;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic [7:0]        wdata_q;
  logic              done_q;
  logic [ADDR_W-1:0] src_lo_d;
  logic [ADDR_W-1:0] src_hi_d;
  logic [ADDR_W-1:0] src_next_d;
  logic [ADDR_W-1:0] dst_lo_d;
  logic [ADDR_W-1:0] dst_hi_d;
  logic              unused_rdata_hi;

  assign idx_d      = idx_q + IDX_W'(1);
  assign src_lo_d   = ADDR_W'(SRC_BASE + 2 * int'(idx_q));
  assign src_hi_d   = ADDR_W'(SRC_BASE + 2 * int'(idx_q) + 1);
  assign src_next_d = ADDR_W'(SRC_BASE + 2 * int'(idx_q) + 2);
  assign dst_lo_d   = ADDR_W'(DST_BASE + 2 * int'(idx_q));
  assign dst_hi_d   = ADDR_W'(DST_BASE + 2 * int'(idx_q) + 1);

  // The hi byte is on mem_rdata during CAPT, so the codeword is encoded straight from the bus.
  hamming_parity_gen u_parity (
    .d_i  ({bus.mem_rdata[2:0], lo_q}),
    .cw_o (cw_d)
  );

  assign unused_rdata_hi = ^bus.mem_rdata[7:3];

  // Outputs are registered on entry to each state, so each bus action lines up with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      cw_q    <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q <= ST_RD_LO;
            idx_q   <= '0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b1;
            addr_q  <= ADDR_W'(SRC_BASE);
          end
        end
        ST_RD_LO: begin
          state_q <= ST_RD_HI;
          rd_en_q <= 1'b1;
          addr_q  <= src_hi_d;
        end
        ST_RD_HI: begin
          state_q <= ST_CAPT;
          lo_q    <= bus.mem_rdata;
        end
        ST_CAPT: begin
          state_q <= ST_WR_LO;
          cw_q    <= cw_d;
          wr_en_q <= 1'b1;
          addr_q  <= dst_lo_d;
          wdata_q <= cw_d[7:0];
        end
        ST_WR_LO: begin
          state_q <= ST_WR_HI;
          wr_en_q <= 1'b1;
          addr_q  <= dst_hi_d;
          wdata_q <= cw_q[15:8];
        end
        ST_WR_HI: begin
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_RD_LO;
            idx_q   <= idx_d;
            rd_en_q <= 1'b1;
            addr_q  <= src_next_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.done      = done_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Bench for hamming_enc_engine: byte memory model, positional Hamming reference encoder/decoder,
// directed vectors, random runs, mid-run start, async reset mid-write and start held across DONE.
module tb_hamming_enc_engine;

  localparam int NUM_MSGS   = 15;
  localparam int SRC_BASE   = 0;
  localparam int DST_BASE   = 30;
  localparam int ADDR_W     = 8;
  localparam int DONE_CYCLE = 5 * NUM_MSGS + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hamming_enc_engine_if #(.ADDR_W(ADDR_W)) bus ();

  hamming_enc_engine #(
    .NUM_MSGS (NUM_MSGS),
    .SRC_BASE (SRC_BASE),
    .DST_BASE (DST_BASE),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [0:255];
  logic       tbWe   = 1'b0;
  logic [7:0] tbAddr = '0;
  logic [7:0] tbData = '0;

  // Memory model: bench preload port, DUT writes, one-cycle read latency.
  always @(posedge clk) begin
    if (tbWe) mem[tbAddr] <= tbData;
    else if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  logic [7:0] msgLo [NUM_MSGS];
  logic [7:0] msgHi [NUM_MSGS];
  int checkCount = 0;
  int failCount  = 0;

  // Data bits fill the non-power-of-two positions; parity k covers positions with bit k set.
  function automatic logic [15:0] refEncode(input logic [10:0] msg);
    logic [15:0] cw;
    logic        par;
    int          k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = msg[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      par = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if (((pos & p) != 0) && (pos != p)) par ^= cw[pos];
      cw[p] = par;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic void refDecode(input logic [15:0] cw, output logic [10:0] msg,
                                    output logic [1:0] flags);
    int   syn;
    int   k;
    logic overall;
    syn = 0;
    k   = 0;
    msg = '0;
    for (int pos = 1; pos < 16; pos++) begin
      if (cw[pos]) syn ^= pos;
      if ((pos & (pos - 1)) != 0) begin
        msg[k] = cw[pos];
        k++;
      end
    end
    overall = ^cw;
    if (syn == 0 && !overall) flags = 2'b00;
    else if (overall)         flags = 2'b01;
    else                      flags = 2'b10;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic writeByte(input int addr, input logic [7:0] data);
    @(negedge clk);
    tbWe   = 1'b1;
    tbAddr = 8'(addr % 256);
    tbData = data;
    @(posedge clk);
    #1 tbWe = 1'b0;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NUM_MSGS; i++) begin
      writeByte(SRC_BASE + 2 * i, msgLo[i]);
      writeByte(SRC_BASE + 2 * i + 1, msgHi[i]);
    end
  endtask

  task automatic fillDst(input logic [7:0] val);
    for (int i = 0; i < 2 * NUM_MSGS; i++) writeByte(DST_BASE + i, val);
  endtask

  task automatic randomMsgs();
    for (int i = 0; i < NUM_MSGS; i++) begin
      msgLo[i] = 8'($urandom);
      msgHi[i] = 8'($urandom);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_done"},  32'(bus.done), 0);
    checkOutput({tag, "_rd_en"}, 32'(bus.mem_rd_en), 0);
    checkOutput({tag, "_wr_en"}, 32'(bus.mem_wr_en), 0);
    checkOutput({tag, "_addr"},  32'(bus.mem_addr), 0);
    checkOutput({tag, "_wdata"}, 32'(bus.mem_wdata), 0);
  endtask

  task automatic startRun(input string tag, input bit hold);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_first_rd_en"}, 32'(bus.mem_rd_en), 1);
    checkOutput({tag, "_first_addr"},  32'(bus.mem_addr), SRC_BASE);
    if (!hold) bus.start = 1'b0;
  endtask

  // pulseAt is the cycle whose opening edge sees an extra start pulse (0 = none).
  task automatic waitDone(input string tag, input int pulseAt, input bit hold);
    int doneCycle;
    int conflicts;
    doneCycle = -1;
    conflicts = 0;
    for (int k = 1; k <= DONE_CYCLE + 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.mem_rd_en && bus.mem_wr_en) conflicts++;
      if (!hold) bus.start = (k == pulseAt - 1);
      if (bus.done) begin
        doneCycle = k + 1;
        break;
      end
    end
    if (!hold) bus.start = 1'b0;
    checkOutput({tag, "_done_cycle"}, doneCycle, DONE_CYCLE);
    checkOutput({tag, "_rd_wr_exclusive"}, conflicts, 0);
  endtask

  task automatic checkIdle(input string tag);
    int accesses;
    accesses = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (bus.mem_rd_en || bus.mem_wr_en) accesses++;
    end
    checkOutput({tag, "_no_access_in_done"}, accesses, 0);
    checkOutput({tag, "_done_held"}, 32'(bus.done), 1);
  endtask

  task automatic checkResults(input string tag);
    logic [15:0] cw;
    logic [15:0] got;
    logic [10:0] dec;
    logic [1:0]  flags;
    for (int i = 0; i < NUM_MSGS; i++) begin
      cw  = refEncode({msgHi[i][2:0], msgLo[i]});
      got = {mem[(DST_BASE + 2 * i + 1) % 256], mem[(DST_BASE + 2 * i) % 256]};
      checkOutput($sformatf("%s_dst_lo[%0d]", tag, i), 32'(got[7:0]), 32'(cw[7:0]));
      checkOutput($sformatf("%s_dst_hi[%0d]", tag, i), 32'(got[15:8]), 32'(cw[15:8]));
      checkOutput($sformatf("%s_src_lo[%0d]", tag, i),
                  32'(mem[(SRC_BASE + 2 * i) % 256]), 32'(msgLo[i]));
      checkOutput($sformatf("%s_src_hi[%0d]", tag, i),
                  32'(mem[(SRC_BASE + 2 * i + 1) % 256]), 32'(msgHi[i]));
      refDecode(got, dec, flags);
      checkOutput($sformatf("%s_dec_flags[%0d]", tag, i), 32'(flags), 0);
      checkOutput($sformatf("%s_dec_msg[%0d]", tag, i), 32'(dec),
                  32'({msgHi[i][2:0], msgLo[i]}));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vectors plus random fill");
    randomMsgs();
    msgLo[0] = 8'h00; msgHi[0] = 8'h00;
    msgLo[1] = 8'hFF; msgHi[1] = 8'h07;
    msgLo[2] = 8'h01; msgHi[2] = 8'h00;
    msgLo[3] = 8'h00; msgHi[3] = 8'h04;
    msgLo[4] = 8'h00; msgHi[4] = 8'hF8;
    applyStimulus();
    fillDst(8'hA5);
    startRun("dir", 1'b0);
    waitDone("dir", 0, 1'b0);
    checkOutput("dir_000_lo", 32'(mem[DST_BASE + 0]), 32'h00);
    checkOutput("dir_000_hi", 32'(mem[DST_BASE + 1]), 32'h00);
    checkOutput("dir_7FF_lo", 32'(mem[DST_BASE + 2]), 32'hFF);
    checkOutput("dir_7FF_hi", 32'(mem[DST_BASE + 3]), 32'hFF);
    checkOutput("dir_001_lo", 32'(mem[DST_BASE + 4]), 32'h0F);
    checkOutput("dir_001_hi", 32'(mem[DST_BASE + 5]), 32'h00);
    checkOutput("dir_400_lo", 32'(mem[DST_BASE + 6]), 32'h17);
    checkOutput("dir_400_hi", 32'(mem[DST_BASE + 7]), 32'h81);
    checkOutput("dir_F8_lo",  32'(mem[DST_BASE + 8]), 32'h00);
    checkOutput("dir_F8_hi",  32'(mem[DST_BASE + 9]), 32'h00);
    checkResults("dir");
    checkIdle("dir");

    $display("[TB] random run with start pulsed at cycle 20");
    randomMsgs();
    applyStimulus();
    fillDst(8'hA5);
    startRun("rnd", 1'b0);
    waitDone("rnd", 20, 1'b0);
    checkResults("rnd");

    $display("[TB] async reset during WR_LO of message 3");
    randomMsgs();
    applyStimulus();
    fillDst(8'hA5);
    startRun("rst", 1'b0);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rst_in_wr_lo_en",   32'(bus.mem_wr_en), 1);
    checkOutput("rst_in_wr_lo_addr", 32'(bus.mem_addr), DST_BASE + 6);
    rst_n = 1'b0;
    #1;
    checkReset("rst_async");
    @(posedge clk);
    #1;
    checkOutput("rst_msg3_lo_unwritten", 32'(mem[DST_BASE + 6]), 32'hA5);
    checkOutput("rst_msg3_hi_unwritten", 32'(mem[DST_BASE + 7]), 32'hA5);
    checkOutput("rst_msg2_hi_written", 32'(mem[DST_BASE + 5]),
                32'(refEncode({msgHi[2][2:0], msgLo[2]}) >> 8));
    @(negedge clk);
    rst_n = 1'b1;
    startRun("rerun", 1'b0);
    waitDone("rerun", 0, 1'b0);
    checkResults("rerun");

    $display("[TB] start held high across DONE");
    fillDst(8'h5A);
    startRun("hold1", 1'b1);
    waitDone("hold1", 0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("hold_done_drops", 32'(bus.done), 0);
    checkOutput("hold_restart_rd_en", 32'(bus.mem_rd_en), 1);
    checkOutput("hold_restart_addr", 32'(bus.mem_addr), SRC_BASE);
    bus.start = 1'b0;
    waitDone("hold2", 0, 1'b0);
    checkResults("hold2");
    checkIdle("hold2");

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
